// File: rtl/b9_resp_misr.sv
// b9_resp_misr: response-capture stage for the b9 benchmark. It folds a
// programmed number of 21-bit b9 output words into a Galois MISR signature
// and compares the final signature against a reference sampled at start.
module b9_resp_misr #(
  parameter logic [20:0] POLY = 21'h080001,  // x^21 + x^19 + 1
  parameter logic [20:0] SEED = 21'h000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] vec_count,
  input  logic [20:0] expected_sig,
  input  logic        in_valid,
  input  logic [20:0] in_data,
  output logic        in_ready,
  output logic        busy,
  output logic        done,
  output logic        match,
  output logic [20:0] signature,
  output logic [15:0] captured,
  output logic [20:0] last_word
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [20:0] sig_q, sig_d;
  logic [20:0] last_q, last_d;
  logic [20:0] exp_q, exp_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] target_q, target_d;
  logic        match_q, match_d;

  logic        fire;
  logic [20:0] sig_step;
  logic [15:0] cnt_inc;

  // in_ready depends only on state, so in_valid never reaches it combinationally.
  assign in_ready = (state_q == RUN);
  assign fire     = in_ready & in_valid;

  // One Galois MISR step: shift left, fold the dropped MSB back through POLY,
  // then mix in the incoming word.
  assign sig_step = {sig_q[19:0], 1'b0} ^ ({21{sig_q[20]}} & POLY) ^ in_data;
  assign cnt_inc  = cnt_q + 16'd1;

  // Next-state and next-register logic; everything holds unless a start or
  // a handshake says otherwise.
  always_comb begin
    // NOTE: every signal written here gets its hold value first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_d  = state_q;
    sig_d    = sig_q;
    last_d   = last_q;
    exp_d    = exp_q;
    cnt_d    = cnt_q;
    target_d = target_q;
    match_d  = match_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          sig_d    = SEED;
          cnt_d    = 16'd0;
          match_d  = 1'b0;
          target_d = vec_count;
          exp_d    = expected_sig;
          if (vec_count == 16'd0) begin
            state_d = DONE;
            match_d = (SEED == expected_sig);
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        // start is deliberately ignored while a run is in progress.
        if (fire) begin
          sig_d  = sig_step;
          cnt_d  = cnt_inc;
          last_d = in_data;
          if (cnt_inc == target_q) begin
            state_d = DONE;
            match_d = (sig_step == exp_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous, active-high reset.
  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments here so every register samples the
    // pre-edge values computed above, independent of statement order.
    if (reset) begin
      state_q  <= IDLE;
      sig_q    <= SEED;
      last_q   <= '0;
      exp_q    <= '0;
      cnt_q    <= '0;
      target_q <= '0;
      match_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sig_q    <= sig_d;
      last_q   <= last_d;
      exp_q    <= exp_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
      match_q  <= match_d;
    end
  end

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign match     = match_q;
  assign signature = sig_q;
  assign captured  = cnt_q;
  assign last_word = last_q;

endmodule
